debug_scanner: RTL and testbench

//  Consumer side of the debug observer mux. It drives the observer's sel/reg_sel inputs to walk
//  PC, IR, ALU_A, ALU_B, ALU_O and then GPR[0..NUM_REGS-1]. After a settle delay it samples the

---
 rtl/debug_pkg.sv | 38 +++
 rtl/debug_scanner.sv | 136 +++++++++++++
 tb/tb_debug_scanner.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared types and constants for the debug observer scanner.
// Item index -> observer (sel, reg_sel) mapping lives here so any observer client can reuse it.
package debug_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EMIT, S_DONE} state_t;

  localparam logic [2:0] SEL_PC   = 3'd0;
  localparam logic [2:0] SEL_IR   = 3'd1;
  localparam logic [2:0] SEL_ALU  = 3'd2;
  localparam logic [2:0] SEL_REG  = 3'd3;
  localparam logic [2:0] SEL_IDLE = 3'd4;

  localparam logic [7:0] ALU_SEL_A   = 8'd1;
  localparam logic [7:0] ALU_SEL_B   = 8'd2;
  localparam logic [7:0] ALU_SEL_O   = 8'd0;
  localparam logic [7:0] FIXED_ITEMS = 8'd5;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] reg_sel;
  } sel_pair_t;

  function automatic sel_pair_t item_to_sel(input logic [7:0] index);
    sel_pair_t p;
    p.sel     = SEL_REG;
    p.reg_sel = index - FIXED_ITEMS;
    case (index)
      8'd0: begin p.sel = SEL_PC;  p.reg_sel = 8'd0;      end
      8'd1: begin p.sel = SEL_IR;  p.reg_sel = 8'd0;      end
      8'd2: begin p.sel = SEL_ALU; p.reg_sel = ALU_SEL_A; end
      8'd3: begin p.sel = SEL_ALU; p.reg_sel = ALU_SEL_B; end
      8'd4: begin p.sel = SEL_ALU; p.reg_sel = ALU_SEL_O; end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/debug_scanner.sv
// Walks the debug observer mux over PC, IR, ALU operands/result and every GPR, streaming samples out.
// Each item: sel/reg_sel held SETTLE_CYCLES cycles, sampled, then held on a valid/ready port until accepted.
module debug_scanner
  import debug_pkg::*;
#(
  parameter int NUM_REGS      = 32,
  parameter int SETTLE_CYCLES = 1,
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [2:0]        sel_o,
  output logic [ADDR_W-1:0] reg_sel_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [7:0]        out_tag_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int         N        = int'(FIXED_ITEMS) + NUM_REGS;
  localparam logic [7:0] LAST_IDX = 8'(N - 1);
  localparam int         CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_END = CW'(SETTLE_CYCLES - 1);

  state_t            state, state_n;
  logic [7:0]        idx, idx_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [2:0]        sel_n;
  logic [ADDR_W-1:0] reg_sel_n;
  logic              valid_n, last_n, done_n;
  logic [DATA_W-1:0] data_n;
  logic [7:0]        tag_n;
  sel_pair_t         next_pair;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= 8'd0;
      cnt         <= '0;
      sel_o       <= SEL_IDLE;
      reg_sel_o   <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_tag_o   <= 8'd0;
      out_last_o  <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      sel_o       <= sel_n;
      reg_sel_o   <= reg_sel_n;
      out_valid_o <= valid_n;
      out_data_o  <= data_n;
      out_tag_o   <= tag_n;
      out_last_o  <= last_n;
      done_o      <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    sel_n     = sel_o;
    reg_sel_n = reg_sel_o;
    valid_n   = out_valid_o;
    data_n    = out_data_o;
    tag_n     = out_tag_o;
    last_n    = out_last_o;
    done_n    = 1'b0;
    next_pair = item_to_sel(idx + 8'd1);

    case (state)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_n   = S_SETTLE;
          idx_n     = 8'd0;
          cnt_n     = '0;
          sel_n     = SEL_PC;
          reg_sel_n = '0;
        end
      end
      S_SETTLE: begin
        cnt_n = cnt + CW'(1);
        if (cnt == CNT_END) begin
          data_n  = data_i;
          tag_n   = idx;
          last_n  = (idx == LAST_IDX);
          valid_n = 1'b1;
          state_n = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready_i) begin
          valid_n = 1'b0;
          if (out_last_o) begin
            state_n   = S_DONE;
            done_n    = 1'b1;
            sel_n     = SEL_IDLE;
            reg_sel_n = '0;
          end else begin
            idx_n     = idx + 8'd1;
            sel_n     = next_pair.sel;
            reg_sel_n = ADDR_W'(next_pair.reg_sel);
            cnt_n     = '0;
            state_n   = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Abort overrides everything above, including a same-cycle handshake.
    if (abort_i && state != S_IDLE) begin
      state_n   = S_IDLE;
      valid_n   = 1'b0;
      sel_n     = SEL_IDLE;
      reg_sel_n = '0;
      done_n    = 1'b0;
    end
  end

  assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_debug_scanner.sv
// Scoreboard bench: observer model feeds the scanner, expected items are queued at start and popped per handshake.
module tb_debug_scanner;
  import debug_pkg::*;

  localparam int NR = 4;
  localparam int N  = 5 + NR;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [2:0]    sel;
  logic [AW-1:0] reg_sel;
  logic [DW-1:0] data_in, out_data;
  logic [7:0]    out_tag;
  logic out_valid, out_last, busy, done;

  // second instance: long settle, single GPR
  logic start3 = 1'b0, abort3 = 1'b0, ready3 = 1'b0;
  logic [2:0]    sel3;
  logic [AW-1:0] reg_sel3;
  logic [DW-1:0] data3 = '0, out_data3;
  logic [7:0]    out_tag3;
  logic valid3, last3, busy3, done3;

  int checks = 0;
  int errors = 0;
  int dones  = 0;
  bit rnd_ready = 1'b0;
  bit last_hs_prev = 1'b0;

  logic [DW-1:0] m_item [N];   // tag-indexed observer contents

  typedef struct {
    logic [DW-1:0] d;
    logic [7:0]    t;
    logic          l;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  debug_scanner #(.NUM_REGS(NR), .SETTLE_CYCLES(1), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
    .sel_o(sel), .reg_sel_o(reg_sel), .data_i(data_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_tag_o(out_tag), .out_last_o(out_last), .busy_o(busy), .done_o(done)
  );

  debug_scanner #(.NUM_REGS(1), .SETTLE_CYCLES(3), .DATA_W(DW), .ADDR_W(AW)) dut3 (
    .clk(clk), .rst(rst), .start_i(start3), .abort_i(abort3),
    .sel_o(sel3), .reg_sel_o(reg_sel3), .data_i(data3),
    .out_valid_o(valid3), .out_ready_i(ready3), .out_data_o(out_data3),
    .out_tag_o(out_tag3), .out_last_o(last3), .busy_o(busy3), .done_o(done3)
  );

  // Observer mux: PC, IR, ALU (A=1,B=2,O=0), GPR file; anything else reads zero.
  always_comb begin
    data_in = '0;
    case (sel)
      3'd0: data_in = m_item[0];
      3'd1: data_in = m_item[1];
      3'd2: begin
        if (reg_sel == 5'd1)      data_in = m_item[2];
        else if (reg_sel == 5'd2) data_in = m_item[3];
        else if (reg_sel == 5'd0) data_in = m_item[4];
      end
      3'd3: if (int'(reg_sel) < NR) data_in = m_item[5 + int'(reg_sel)];
      default: data_in = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) m_item[i] = $urandom;
  endtask

  // Reference: a full scan yields every tag in order, value = observer content for that tag.
  task automatic start_scan();
    for (int t = 0; t < N; t++) begin
      exp_t e;
      e.d = m_item[t];
      e.t = 8'(t);
      e.l = (t == N - 1);
      exp_q.push_back(e);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while (!done && k < budget) begin tick(); k++; end
    if (!done) chk({nm, "_timeout"}, 64'(k), 64'(budget + 1));
  endtask

  // Monitor: pop and compare on each handshake; done must follow the last handshake with nothing left queued.
  always @(negedge clk) begin
    if (rst) begin
      last_hs_prev <= 1'b0;
    end else begin
      if (done) begin
        dones++;
        chk("done_after_last", {31'd0, last_hs_prev, 32'(exp_q.size())}, {31'd0, 1'b1, 32'd0});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_item", {24'd0, out_tag, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("item_tag%0d", e.t), {23'd0, out_last, out_tag, out_data}, {23'd0, e.l, e.t, e.d});
        end
      end
      last_hs_prev <= out_valid && out_ready && out_last;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int k, first_valid, d0;
    logic [DW-1:0] snap_d;
    logic [7:0]    snap_t;

    for (int i = 0; i < N; i++) m_item[i] = '0;
    rst = 1'b1;
    repeat (2) tick();
    chk("reset_state", {sel, reg_sel, out_valid, out_data, out_tag, out_last, busy, done},
        {3'd4, 5'd0, 1'b0, 32'd0, 8'd0, 3'b000});
    rst = 1'b0;
    tick();

    // Fixed pattern, ready tied high: timing of first valid and of done.
    m_item[0] = 32'h100; m_item[1] = 32'h200; m_item[2] = 32'h300;
    m_item[3] = 32'h400; m_item[4] = 32'h500;
    for (int i = 0; i < NR; i++) m_item[5 + i] = 32'hA0 + 32'(i);
    out_ready = 1'b1;
    start_scan();
    chk("t2_busy", 64'(busy), 64'd1);
    k = 0; first_valid = -1;
    while (!done && k < 100) begin
      tick(); k++;
      if (out_valid && first_valid < 0) first_valid = k;
    end
    chk("t2_first_valid_edge", 64'(first_valid), 64'd1);
    chk("t2_start_to_done_edges", 64'(k + 1), 64'd19);
    tick();
    chk("t2_done_one_cycle", {62'd0, done, busy}, 64'd0);

    // Backpressure on tag 2.
    fill_random();
    out_ready = 1'b1;
    start_scan();
    k = 0;
    while (!(sel == 3'd2 && reg_sel == 5'd1 && !out_valid) && k < 50) begin tick(); k++; end
    out_ready = 1'b0;
    tick();
    chk("t3_valid_tag2", {55'd0, out_valid, out_tag}, {55'd0, 1'b1, 8'd2});
    snap_d = out_data; snap_t = out_tag;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("t3_hold%0d", c), {out_valid, sel, reg_sel, out_tag, out_data},
          {1'b1, 3'd2, 5'd1, snap_t, snap_d});
    end
    out_ready = 1'b1;
    wait_done("t3", 100);
    tick();

    // Abort during settle of tag 6, then a fresh scan starts from tag 0.
    fill_random();
    start_scan();
    k = 0;
    while (!(sel == 3'd3 && reg_sel == 5'd1 && !out_valid) && k < 50) begin tick(); k++; end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    chk("t4_after_abort", {59'd0, out_valid, busy, sel}, {59'd0, 1'b0, 1'b0, 3'd4});
    d0 = dones;
    repeat (10) tick();
    chk("t4_no_done", 64'(dones), 64'(d0));
    start_scan();
    wait_done("t4_restart", 100);
    tick();

    // start while busy is ignored; start+abort in idle does nothing.
    fill_random();
    d0 = dones;
    start_scan();
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done("t5", 100);
    repeat (6) tick();
    chk("t5_single_scan", {31'd0, busy, 32'(dones)}, {31'd0, 1'b0, 32'(d0 + 1)});
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t5_start_abort_idle", {61'd0, busy, sel}, {61'd0, 1'b0, 3'd4});

    // Reset asserted while an item is waiting.
    fill_random();
    out_ready = 1'b0;
    start_scan();
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    chk("t1_in_emit", 64'(out_valid), 64'd1);
    rst = 1'b1;
    repeat (2) tick();
    chk("t1_reset_midscan", {sel, reg_sel, out_valid, out_data, out_tag, out_last, busy, done},
        {3'd4, 5'd0, 1'b0, 32'd0, 8'd0, 3'b000});
    rst = 1'b0;
    exp_q.delete();
    tick();

    // Randomised scans with random backpressure.
    for (int s = 0; s < 4; s++) begin
      fill_random();
      rnd_ready = 1'b1;
      start_scan();
      wait_done($sformatf("rand%0d", s), 400);
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      tick();
    end

    // Long settle: sample taken in the last settle cycle.
    start3 = 1'b1; tick(); start3 = 1'b0;
    data3 = 32'd1; chk("t6_valid_e0", 64'(valid3), 64'd0);
    tick(); data3 = 32'd2; chk("t6_valid_e1", 64'(valid3), 64'd0);
    tick(); data3 = 32'd3; chk("t6_valid_e2", 64'(valid3), 64'd0);
    tick();
    chk("t6_capture", {23'd0, valid3, out_tag3, out_data3}, {23'd0, 1'b1, 8'd0, 32'd3});
    ready3 = 1'b1;
    k = 0;
    while (!done3 && k < 100) begin tick(); k++; end
    chk("t6_done", 64'(done3), 64'd1);

    repeat (3) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
